// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use and branch-operand
// hazards, divider start/ready handshake, memory-wait freeze and deferred exception flush.
module pipe_hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rs_d,
  input  logic [REGW-1:0] rt_d,
  input  logic [REGW-1:0] rt_e,
  input  logic            memtoreg_e,
  input  logic            regwrite_e,
  input  logic [REGW-1:0] writereg_e,
  input  logic            memtoreg_m,
  input  logic [REGW-1:0] writereg_m,
  input  logic            branch_d,
  input  logic            jumpr_d,
  input  logic            div_e,
  input  logic            div_ready,
  input  logic            i_stall,
  input  logic            d_stall,
  input  logic            except_m,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            stall_m,
  output logic            stall_w,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            flush_w,
  output logic            div_start,
  output logic            div_abort,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t      r_state;
  div_state_t      w_state_nxt;
  logic            r_pending;
  logic [CNTW-1:0] r_stall_cnt;

  logic w_mem_stall;
  logic w_lwstall;
  logic w_brstall;
  logic w_flush_now;

  // Register index r is a nonzero match for either source operand in D.
  function automatic logic reg_hit(input logic [REGW-1:0] r,
                                   input logic [REGW-1:0] a,
                                   input logic [REGW-1:0] b);
    return (r != {REGW{1'b0}}) && ((r == a) || (r == b));
  endfunction

  assign w_mem_stall = i_stall | d_stall;
  assign w_lwstall   = memtoreg_e & reg_hit(rt_e, rs_d, rt_d);
  assign w_brstall   = (branch_d | jumpr_d) &
                       ((regwrite_e & reg_hit(writereg_e, rs_d, rt_d)) |
                        (memtoreg_m & reg_hit(writereg_m, rs_d, rt_d)));
  // An exception seen during a memory wait is parked until the wait ends.
  assign w_flush_now = (except_m | r_pending) & ~w_mem_stall;

  // Divider FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Divider FSM next state; a flush cancels any divide in flight.
  always_comb begin
    w_state_nxt = r_state;
    if (w_flush_now) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = (div_e && !w_mem_stall) ? S_BUSY : S_IDLE;
        S_BUSY:  w_state_nxt = div_ready ? S_DONE : S_BUSY;
        S_DONE:  w_state_nxt = w_mem_stall ? S_DONE : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage enables/clears and divider handshake, highest priority first.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    stall_m   = 1'b0;
    stall_w   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    flush_w   = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    if (rst) begin
      div_abort = 1'b0;
    end else if (w_flush_now) begin
      flush_d   = 1'b1;
      flush_e   = 1'b1;
      flush_m   = 1'b1;
      flush_w   = 1'b1;
      div_abort = (r_state != S_IDLE);
    end else if (w_mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      stall_w = 1'b1;
    end else if ((r_state == S_BUSY) || ((r_state == S_IDLE) && div_e)) begin
      // E holds the divide; M receives a bubble.
      div_start = (r_state == S_IDLE);
      stall_f   = 1'b1;
      stall_d   = 1'b1;
      stall_e   = 1'b1;
      flush_m   = 1'b1;
    end else if (w_lwstall || w_brstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      stall_f = 1'b0;
    end
  end

  // Pending exception flag.
  always_ff @(posedge clk) begin
    if (rst)                           r_pending <= 1'b0;
    else if (w_flush_now)              r_pending <= 1'b0;
    else if (except_m && w_mem_stall)  r_pending <= 1'b1;
    else                               r_pending <= r_pending;
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk) begin
    if (rst)                                           r_stall_cnt <= {CNTW{1'b0}};
    else if (stall_f && (r_stall_cnt != {CNTW{1'b1}})) r_stall_cnt <= r_stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    else                                               r_stall_cnt <= r_stall_cnt;
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl with a priority-rule reference model.
module tb_pipe_hazard_ctrl;
  localparam int REGW = 5;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [REGW-1:0] rs_d, rt_d, rt_e, writereg_e, writereg_m;
  logic memtoreg_e, regwrite_e, memtoreg_m, branch_d, jumpr_d;
  logic div_e, div_ready, i_stall, d_stall, except_m;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w, div_start, div_abort;
  logic [CNTW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  // model state: divide in flight, result held, parked exception, stall counter
  logic m_busy = 1'b0, m_done = 1'b0, m_pend = 1'b0;
  logic [CNTW-1:0] m_cnt = '0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .rt_e(rt_e),
    .memtoreg_e(memtoreg_e), .regwrite_e(regwrite_e), .writereg_e(writereg_e),
    .memtoreg_m(memtoreg_m), .writereg_m(writereg_m), .branch_d(branch_d),
    .jumpr_d(jumpr_d), .div_e(div_e), .div_ready(div_ready), .i_stall(i_stall),
    .d_stall(d_stall), .except_m(except_m), .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w), .flush_d(flush_d),
    .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w), .div_start(div_start),
    .div_abort(div_abort), .stall_cnt(stall_cnt)
  );

  // {stall_f..stall_w, flush_d..flush_w, div_start, div_abort}
  wire [10:0] obs = {stall_f, stall_d, stall_e, stall_m, stall_w,
                     flush_d, flush_e, flush_m, flush_w, div_start, div_abort};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic clear_inputs();
    rst = 1'b0; rs_d = '0; rt_d = '0; rt_e = '0; writereg_e = '0; writereg_m = '0;
    memtoreg_e = 1'b0; regwrite_e = 1'b0; memtoreg_m = 1'b0; branch_d = 1'b0;
    jumpr_d = 1'b0; div_e = 1'b0; div_ready = 1'b0; i_stall = 1'b0; d_stall = 1'b0;
    except_m = 1'b0;
  endtask

  function automatic logic hit(input logic [REGW-1:0] r);
    return (r != 0) && (r == rs_d || r == rt_d);
  endfunction

  // Compare against the model for this cycle, then advance model and clock.
  task automatic tick(input string tag);
    logic [10:0] e;
    logic mem, fl, haz, divhold;
    logic nb, nd, np;
    logic [CNTW-1:0] nc;
    #1;
    mem = i_stall | d_stall;
    fl = (except_m | m_pend) & ~mem;
    haz = (memtoreg_e & hit(rt_e)) |
          ((branch_d | jumpr_d) & ((regwrite_e & hit(writereg_e)) | (memtoreg_m & hit(writereg_m))));
    divhold = m_busy | (div_e & ~m_busy & ~m_done);
    e = 11'b0;
    if (rst)          e = 11'b0;
    else if (fl)      e = {5'b00000, 4'b1111, 1'b0, m_busy | m_done};
    else if (mem)     e = {5'b11111, 4'b0000, 2'b00};
    else if (divhold) e = {5'b11100, 4'b0010, ~m_busy, 1'b0};
    else if (haz)     e = {5'b11000, 4'b0100, 2'b00};
    chk({tag, ":outs"}, {21'b0, obs}, {21'b0, e});
    chk({tag, ":cnt"}, {28'b0, stall_cnt}, {28'b0, m_cnt});
    nb = m_busy; nd = m_done; np = m_pend;
    nc = (e[10] && m_cnt != {CNTW{1'b1}}) ? m_cnt + 1'b1 : m_cnt;
    if (rst) begin
      nb = 0; nd = 0; np = 0; nc = '0;
    end else if (fl) begin
      nb = 0; nd = 0; np = 0;
    end else begin
      if (except_m && mem) np = 1;
      if (m_busy && div_ready) begin nb = 0; nd = 1; end
      else if (m_done && !mem) nd = 0;
      else if (!m_busy && !m_done && div_e && !mem) nb = 1;
    end
    @(posedge clk);
    m_busy = nb; m_done = nd; m_pend = np; m_cnt = nc;
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    #1 chk("reset_outs", {21'b0, obs}, 32'd0);
    tick("reset");
    rst = 1'b0;

    // load-use
    memtoreg_e = 1; rt_e = 5; rs_d = 5;
    #1 chk("lw_stall", {21'b0, obs}, {21'b0, 11'b11000_0100_00});
    tick("lw");
    rt_e = 0;
    #1 chk("lw_r0", {21'b0, obs}, 32'd0);
    tick("lw_r0");
    clear_inputs();

    // branch hazard: producer in E, then as a load in M, then non-load in M
    branch_d = 1; regwrite_e = 1; writereg_e = 7; rt_d = 7;
    #1 chk("br_e", {21'b0, obs}, {21'b0, 11'b11000_0100_00});
    tick("br_e");
    regwrite_e = 0; writereg_e = 0; memtoreg_m = 1; writereg_m = 7;
    #1 chk("br_m_load", {31'b0, stall_f}, 32'd1);
    tick("br_m_load");
    memtoreg_m = 0;
    #1 chk("br_m_nonload", {21'b0, obs}, 32'd0);
    tick("br_m_nonload");
    clear_inputs();

    // divide: start, busy, ready, done with div_e still high
    div_e = 1;
    #1 chk("div_start", {21'b0, obs}, {21'b0, 11'b11100_0010_10});
    tick("div0");
    #1 chk("div_busy", {21'b0, obs}, {21'b0, 11'b11100_0010_00});
    tick("div1");
    tick("div2");
    div_ready = 1;
    #1 chk("div_ready_cyc", {21'b0, obs}, {21'b0, 11'b11100_0010_00});
    tick("div3");
    div_ready = 0;
    #1 chk("div_done_nostart", {21'b0, obs}, 32'd0);
    tick("div_done");
    div_e = 0;
    tick("div_idle");

    // memory wait overlapping div_ready
    div_e = 1; tick("mw_start");
    div_e = 0; tick("mw_busy");
    d_stall = 1;
    #1 chk("mw_all_stall", {21'b0, obs}, {21'b0, 11'b11111_0000_00});
    tick("mw1");
    div_ready = 1; tick("mw2");
    div_ready = 0; div_e = 1; tick("mw3");
    d_stall = 0;
    #1 chk("mw_done", {21'b0, obs}, 32'd0);
    tick("mw_done");
    div_e = 0; tick("mw_idle");

    // deferred exception with a second pulse during the wait
    i_stall = 1; except_m = 1;
    #1 chk("exc_wait", {31'b0, flush_d}, 32'd0);
    tick("exc1");
    except_m = 0; tick("exc2");
    except_m = 1; tick("exc3");
    except_m = 0; tick("exc4");
    i_stall = 0;
    #1 chk("exc_flush", {21'b0, obs}, {21'b0, 11'b00000_1111_00});
    tick("exc_flush");
    #1 chk("exc_once", {21'b0, obs}, 32'd0);
    tick("exc_once");

    // exception aborts a divide
    div_e = 1; tick("ab_start");
    div_e = 0; tick("ab_busy");
    except_m = 1;
    #1 chk("abort", {21'b0, obs}, {21'b0, 11'b00000_1111_01});
    tick("abort");
    except_m = 0;
    #1 chk("abort_idle", {21'b0, obs}, 32'd0);
    tick("abort_idle");

    // counter saturation, then reset
    i_stall = 1;
    for (int i = 0; i < 20; i++) tick("sat");
    #1 chk("sat_hold", {28'b0, stall_cnt}, 32'd15);
    i_stall = 0; rst = 1;
    #1 chk("rst_outs", {21'b0, obs}, 32'd0);
    tick("rst");
    rst = 0;
    #1 chk("rst_cnt", {28'b0, stall_cnt}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst        = ($urandom_range(0, 99) == 0);
      rs_d       = REGW'($urandom_range(0, 3));
      rt_d       = REGW'($urandom_range(0, 3));
      rt_e       = REGW'($urandom_range(0, 3));
      writereg_e = REGW'($urandom_range(0, 3));
      writereg_m = REGW'($urandom_range(0, 3));
      memtoreg_e = ($urandom_range(0, 3) == 0);
      regwrite_e = ($urandom_range(0, 1) == 0);
      memtoreg_m = ($urandom_range(0, 3) == 0);
      branch_d   = ($urandom_range(0, 3) == 0);
      jumpr_d    = ($urandom_range(0, 7) == 0);
      div_e      = ($urandom_range(0, 3) == 0);
      div_ready  = ($urandom_range(0, 5) == 0);
      i_stall    = ($urandom_range(0, 4) == 0);
      d_stall    = ($urandom_range(0, 4) == 0);
      except_m   = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage MIPS pipeline.
- Drives the enable (as inverted stall) and clear inputs of the F/D/E/M/W pipeline registers.
- Detects load-use and branch-operand hazards.
- Sequences the multicycle divider with a start/ready handshake.
- Freezes the pipe on instruction/data memory wait.
- Holds a pending exception flush until the memory wait ends.

Parameters:
- REGW, 5, register-index width.
- CNTW, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rs_d  in  REGW  source register 1 of the instruction in D
- rt_d  in  REGW  source register 2 of the instruction in D
- rt_e  in  REGW  rt of the instruction in E
- memtoreg_e  in  1  instruction in E is a load
- regwrite_e  in  1  instruction in E writes the register file
- writereg_e  in  REGW  destination register of the instruction in E
- memtoreg_m  in  1  instruction in M is a load
- writereg_m  in  REGW  destination register of the instruction in M
- branch_d  in  1  instruction in D is a branch
- jumpr_d  in  1  instruction in D is jr/jalr
- div_e  in  1  instruction in E is div/divu
- div_ready  in  1  divider result valid (single-cycle pulse)
- i_stall  in  1  instruction memory not ready
- d_stall  in  1  data memory not ready
- except_m  in  1  exception taken in M (single-cycle pulse)
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1 each  hold the corresponding stage register (en = ~stall)
- flush_d, flush_e, flush_m, flush_w  out  1 each  clear the corresponding stage register
- div_start  out  1  single-cycle start pulse to the divider
- div_abort  out  1  cancel an in-flight divide
- stall_cnt  out  CNTW  count of cycles with stall_f=1

Behaviour:
- Derived signals (combinational):
  - mem_stall = i_stall | d_stall.
  - lwstall = memtoreg_e & rt_e!=0 & (rt_e==rs_d | rt_e==rt_d).
  - brstall = (branch_d|jumpr_d) & ((regwrite_e & writereg_e!=0 & writereg_e∈{rs_d,rt_d}) | (memtoreg_m & writereg_m!=0 & writereg_m∈{rs_d,rt_d})).
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: if div_e & !flush_now → BUSY and div_start=1 for that cycle.
  - BUSY: div_ready → DONE.
  - DONE: !mem_stall → IDLE. While in DONE, div_start is never asserted even if div_e remains high.
- Flush pending flag:
  - Set by except_m when mem_stall=1.
  - flush_now = (except_m | pending) & !mem_stall.
  - Pending is cleared in the cycle flush_now=1.
- Output priority, highest first:
  1. rst: all stall/flush=0, div_start=0, div_abort=0, FSM=IDLE, pending=0, stall_cnt=0.
  2. flush_now:
     - flush_d=flush_e=flush_m=flush_w=1.
     - All stalls=0, so F loads the handler PC.
     - If FSM≠IDLE: div_abort=1 and FSM→IDLE.
     - No div_start in this cycle.
  3. mem_stall: stall_f..stall_w=1; all flushes=0; FSM holds state, except BUSY still advances to DONE on div_ready.
  4. FSM=BUSY, or FSM=IDLE with div_start: stall_f=stall_d=stall_e=1, flush_m=1 (bubble into M), stall_m=stall_w=0.
  5. lwstall | brstall: stall_f=stall_d=1, flush_e=1; all else 0.
  6. Otherwise all 0.
- Outputs are combinational from registered state plus inputs. Hazard stalls take effect the same cycle they are detected.
- Divide latency seen by the pipe: E is held from the div_start cycle through BUSY and advances in the DONE cycle.
- stall_cnt: +1 on every cycle with stall_f=1; saturates at all-ones; cleared only by rst.
- Reset while BUSY: FSM→IDLE, no div_abort pulse. The divider is reset by the same rst.
- except_m while pending=1: no additional effect; one flush only.

Test Plan:
- Load-use: memtoreg_e=1, rt_e=5, rs_d=5 → stall_f=stall_d=flush_e=1 that cycle. Same with rt_e=0 → all 0.
- Branch hazard: branch_d=1, regwrite_e=1, writereg_e=rt_d=7 → stall_f=stall_d=flush_e=1. Next cycle, with the producer moved to M as memtoreg_m=1, writereg_m=7 → stall again. With a non-load in M → no stall.
- Divide:
  - div_e=1 at cycle 0 → div_start=1 at cycle 0 only.
  - stall_f/d/e=1 and flush_m=1 for cycles 0 through the div_ready cycle.
  - DONE at the next cycle with all stalls 0, then IDLE. No second div_start while div_e stays high in DONE.
- Memory wait during divide: d_stall=1 for 3 cycles overlapping div_ready → all five stalls=1 during the wait; FSM reaches DONE; DONE persists until d_stall=0, then →IDLE.
- Deferred exception: except_m pulse while i_stall=1 for 4 cycles → no flush during the wait. Cycle after i_stall falls: flush_d..flush_w=1 once and all stalls=0. A second except_m during the wait still yields a single flush.
- Flush aborts divide and counter: except_m during BUSY with no memory wait → div_abort=1, all flushes=1, FSM=IDLE next cycle. Preloaded stall_cnt=2^CNTW−1 stays saturated on further stalls; rst → stall_cnt=0 and all outputs 0.
